// File: rtl/udp_rx_demux.sv
// UDP receive stage: strips the 8-byte UDP header, routes the payload to the
// channel whose port matches the destination port, and counts dropped datagrams.
//
// state   | meaning
// IDLE    | waiting for the first header beat
// HDR     | collecting the remaining header beats
// PAYLOAD | forwarding payload beats to the selected channel
// DROP    | discarding beats until the end of the datagram
module udp_rx_demux #(
  parameter int                  DATA_W   = 32,
  parameter int                  KEEP_W   = DATA_W / 8,
  parameter int                  LEN_W    = $clog2(KEEP_W) + 1,
  parameter int                  CH_N     = 4,
  parameter logic [CH_N*16-1:0]  CH_PORTS = {16'h4000, 16'h3000, 16'h2000, 16'h1234},
  parameter int                  CNT_W    = 16
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              valid_i,
  input  logic              cancel_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              last_i,
  input  logic              ip_cs_err_i,
  output logic [CH_N-1:0]   app_valid_o,
  output logic [DATA_W-1:0] app_data_o,
  output logic [LEN_W-1:0]  app_len_o,
  output logic              app_last_o,
  output logic [CH_N-1:0]   app_cancel_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);

  localparam int         HDR_BEATS = 8 / KEEP_W;
  localparam logic [1:0] HDR_LAST  = 2'(HDR_BEATS - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_HDR     = 2'd1;
  localparam logic [1:0] S_PAYLOAD = 2'd2;
  localparam logic [1:0] S_DROP    = 2'd3;

  logic [1:0]        r_state;
  logic [1:0]        r_hbeat;
  logic [5:2][7:0]   r_hb;
  logic [CH_N-1:0]   r_sel;
  logic [15:0]       r_len;
  logic [15:0]       r_cnt;
  logic [CH_N-1:0]   r_app_valid;
  logic [DATA_W-1:0] r_app_data;
  logic [LEN_W-1:0]  r_app_len;
  logic              r_app_last;
  logic [CH_N-1:0]   r_app_cancel;
  logic [CNT_W-1:0]  r_drop_cnt;

  logic              w_beat;
  logic              w_in_hdr;
  logic [1:0]        w_hidx;
  logic              w_hdr_done;
  logic              w_short;
  logic [5:2][7:0]   w_hb;
  logic [15:0]       w_dst;
  logic [15:0]       w_ulen;
  logic [CH_N-1:0]   w_match;
  logic              w_bad;
  logic              w_drop;
  logic [15:0]       w_len_ext;
  logic [15:0]       w_total;

  assign w_beat     = valid_i & ~cancel_i;
  assign w_in_hdr   = (r_state == S_IDLE) || (r_state == S_HDR);
  assign w_hidx     = (r_state == S_IDLE) ? 2'd0 : r_hbeat;
  assign w_hdr_done = (w_hidx == HDR_LAST);
  // A short final header beat means fewer than 8 header bytes arrived.
  assign w_short    = w_hdr_done & last_i & (len_i != LEN_W'(KEEP_W));

  // Only the dst port and length bytes matter; merge the current beat so
  // the match can be resolved on the final header beat itself.
  always_comb begin
    w_hb = r_hb;
    for (int k = 2; k <= 5; k++) begin
      if (2'(k / KEEP_W) == w_hidx) w_hb[k] = data_i[8*(k % KEEP_W) +: 8];
    end
  end

  assign w_dst  = {w_hb[2], w_hb[3]};
  assign w_ulen = {w_hb[4], w_hb[5]};

  // Scan from the top so the lowest matching index wins.
  always_comb begin
    w_match = '0;
    for (int i = CH_N - 1; i >= 0; i--) begin
      if (CH_PORTS[16*i +: 16] == w_dst) begin
        w_match    = '0;
        w_match[i] = 1'b1;
      end
    end
  end

  assign w_bad     = ~(|w_match) | (w_ulen < 16'd8);
  assign w_drop    = w_in_hdr & w_beat & (w_hdr_done ? (w_short | w_bad) : last_i);
  assign w_len_ext = {{(16-LEN_W){1'b0}}, len_i};
  assign w_total   = 16'd8 + r_cnt + w_len_ext;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_state      <= S_IDLE;
      r_hbeat      <= 2'd0;
      r_hb         <= '0;
      r_sel        <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_app_valid  <= '0;
      r_app_data   <= '0;
      r_app_len    <= '0;
      r_app_last   <= 1'b0;
      r_app_cancel <= '0;
    end else begin
      r_app_valid  <= '0;
      r_app_last   <= 1'b0;
      r_app_cancel <= '0;
      case (r_state)
        S_IDLE, S_HDR: begin
          if ((r_state == S_HDR) && cancel_i) begin
            r_state <= (valid_i & last_i) ? S_IDLE : S_DROP;
          end else if (w_beat) begin
            r_hb    <= w_hb;
            r_hbeat <= w_hidx + 2'd1;
            if (w_drop) begin
              r_state <= last_i ? S_IDLE : S_DROP;
            end else if (!w_hdr_done) begin
              r_state <= S_HDR;
            end else begin
              r_sel   <= w_match;
              r_len   <= w_ulen;
              r_cnt   <= '0;
              r_state <= last_i ? S_IDLE : S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          if (cancel_i) begin
            r_app_cancel <= r_sel;
            r_state      <= (valid_i & last_i) ? S_IDLE : S_DROP;
          end else if (valid_i) begin
            r_app_valid <= r_sel;
            r_app_data  <= data_i;
            r_app_len   <= len_i;
            r_app_last  <= last_i;
            r_cnt       <= r_cnt + w_len_ext;
            if (last_i) begin
              if ((w_total != r_len) || ip_cs_err_i) r_app_cancel <= r_sel;
              r_state <= S_IDLE;
            end
          end
        end
        default: begin
          if (valid_i & last_i) r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_drop_cnt <= '0;
    end else if (w_drop && (r_drop_cnt != {CNT_W{1'b1}})) begin
      r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end
  end

  assign app_valid_o  = r_app_valid;
  assign app_data_o   = r_app_data;
  assign app_len_o    = r_app_len;
  assign app_last_o   = r_app_last;
  assign app_cancel_o = r_app_cancel;
  assign drop_cnt_o   = r_drop_cnt;

endmodule

// File: tb/tb_udp_rx_demux.sv
// Bench for udp_rx_demux: directed scenarios plus random datagrams checked
// against a byte-level reference model of UDP demultiplexing.
module tb_udp_rx_demux;

  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  // default-parameter DUT and a narrow-counter twin sharing its inputs
  logic        valid, cancel, last, cs_err;
  logic [31:0] data;
  logic [2:0]  len;
  logic [3:0]  av, ac, s_av, s_ac;
  logic [31:0] ad, s_ad;
  logic [2:0]  al, s_al;
  logic        alast, s_alast;
  logic [15:0] dc;
  logic [3:0]  s_dc;

  // 64-bit DUT
  logic        v64, c64, last64, cs64;
  logic [63:0] d64, a64_d;
  logic [3:0]  l64, a64_l, a64_v, a64_c;
  logic        a64_last;
  logic [15:0] a64_dc;

  udp_rx_demux u_dut (
    .clk(clk), .nreset(nreset), .valid_i(valid), .cancel_i(cancel), .data_i(data),
    .len_i(len), .last_i(last), .ip_cs_err_i(cs_err), .app_valid_o(av),
    .app_data_o(ad), .app_len_o(al), .app_last_o(alast), .app_cancel_o(ac),
    .drop_cnt_o(dc));

  udp_rx_demux #(.CNT_W(4)) u_sat (
    .clk(clk), .nreset(nreset), .valid_i(valid), .cancel_i(cancel), .data_i(data),
    .len_i(len), .last_i(last), .ip_cs_err_i(cs_err), .app_valid_o(s_av),
    .app_data_o(s_ad), .app_len_o(s_al), .app_last_o(s_alast), .app_cancel_o(s_ac),
    .drop_cnt_o(s_dc));

  udp_rx_demux #(.DATA_W(64)) u_dut64 (
    .clk(clk), .nreset(nreset), .valid_i(v64), .cancel_i(c64), .data_i(d64),
    .len_i(l64), .last_i(last64), .ip_cs_err_i(cs64), .app_valid_o(a64_v),
    .app_data_o(a64_d), .app_len_o(a64_l), .app_last_o(a64_last), .app_cancel_o(a64_c),
    .drop_cnt_o(a64_dc));

  int n_cmp = 0;
  int n_err = 0;
  int drops = 0;
  logic [15:0] ports [4] = '{16'h1234, 16'h2000, 16'h3000, 16'h4000};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive32(input logic v, input logic c, input logic [31:0] d,
                         input logic [2:0] l, input logic lst, input logic cs);
    @(negedge clk);
    valid = v; cancel = c; data = d; len = l; last = lst; cs_err = cs;
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [3:0] ev, input logic [3:0] ec,
                           input logic el, input logic [31:0] ed, input logic [2:0] elen);
    chk({tag, ".valid"}, av, ev);
    chk({tag, ".cancel"}, ac, ec);
    chk({tag, ".last"}, alast, el);
    if (ev != 4'd0) begin
      chk({tag, ".data"}, ad, ed);
      chk({tag, ".len"}, al, elen);
    end
  endtask

  task automatic gap();
    drive32(1'b0, 1'b0, $urandom, 3'(4), 1'b0, 1'b0);
    check_out("gap", 4'd0, 4'd0, 1'b0, 32'd0, 3'd0);
  endtask

  function automatic bq_t mk(input logic [15:0] dst, input logic [15:0] ulen, input int pb);
    bq_t q;
    q.push_back(8'($urandom)); q.push_back(8'($urandom));
    q.push_back(dst[15:8]);    q.push_back(dst[7:0]);
    q.push_back(ulen[15:8]);   q.push_back(ulen[7:0]);
    q.push_back(8'($urandom)); q.push_back(8'($urandom));
    for (int i = 0; i < pb; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  // Reference model: derives routing and errors from the byte stream itself.
  task automatic send(input string tag, input bq_t q, input int cbeat, input logic cs,
                      input int gap_pct, input int max_beats);
    int total, n, ch, bl;
    logic hdr_ok, good, lst, csv;
    logic [15:0] dst, ulen;
    logic [3:0] oh, ev, ec;
    logic el;
    logic [31:0] w;
    total  = q.size();
    n      = (total + 3) / 4;
    hdr_ok = (total >= 8);
    dst    = hdr_ok ? {q[2], q[3]} : 16'd0;
    ulen   = hdr_ok ? {q[4], q[5]} : 16'd0;
    ch     = -1;
    for (int i = 0; i < 4; i++) if (ch < 0 && ports[i] == dst) ch = i;
    good = hdr_ok && (ch >= 0) && (ulen >= 16'd8);
    oh   = good ? (4'b0001 << ch) : 4'd0;
    if (!good) drops++;
    for (int b = 0; b < n && b < max_beats; b++) begin
      if (gap_pct > 0 && $urandom_range(0, 99) < gap_pct) gap();
      for (int j = 0; j < 4; j++)
        w[8*j +: 8] = (4*b + j < total) ? q[4*b + j] : 8'($urandom);
      bl  = (b < n - 1) ? 4 : total - 4*(n - 1);
      lst = (b == n - 1);
      csv = lst ? cs : 1'($urandom);
      drive32(1'b1, (b == cbeat), w, 3'(bl), lst, csv);
      ev = 4'd0; ec = 4'd0; el = 1'b0;
      if (good && b >= 2) begin
        if (b == cbeat) ec = oh;
        else if (cbeat < 0 || b < cbeat) begin
          ev = oh;
          el = lst;
          if (lst && ((total != int'(ulen)) || cs)) ec = oh;
        end
      end
      check_out(tag, ev, ec, el, w, 3'(bl));
    end
    chk({tag, ".drop_cnt"}, dc, 16'(drops));
    chk({tag, ".drop_sat"}, s_dc, (drops > 15) ? 4'hF : 4'(drops));
  endtask

  task automatic drive64(input logic [63:0] d, input logic [3:0] l, input logic lst);
    @(negedge clk);
    v64 = 1'b1; c64 = 1'b0; d64 = d; l64 = l; last64 = lst; cs64 = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bq_t q;
    logic [63:0] w0, w1;
    int pb, n, cb;
    logic [15:0] dst, ulen;

    nreset = 1'b0;
    valid = 0; cancel = 0; data = 0; len = 0; last = 0; cs_err = 0;
    v64 = 0; c64 = 0; d64 = 0; l64 = 0; last64 = 0; cs64 = 0;
    #12;
    chk("rst.valid", av, 4'd0);
    chk("rst.cancel", ac, 4'd0);
    chk("rst.last", alast, 1'b0);
    chk("rst.data", ad, 32'd0);
    chk("rst.len", al, 3'd0);
    chk("rst.drop", dc, 16'd0);
    chk("rst.valid64", a64_v, 4'd0);
    @(negedge clk);
    nreset = 1'b1;

    send("ch1_l20", mk(16'h2000, 16'd20, 12), -1, 1'b0, 0, 99);
    send("nomatch", mk(16'h5555, 16'd12, 4), -1, 1'b0, 0, 99);
    send("short_l", mk(16'h1234, 16'd6, 4), -1, 1'b0, 0, 99);
    send("len_err", mk(16'h1234, 16'd22, 12), -1, 1'b0, 0, 99);
    send("cs_err", mk(16'h1234, 16'd20, 12), -1, 1'b1, 0, 99);
    send("cancel", mk(16'h4000, 16'd24, 16), 3, 1'b0, 0, 99);
    send("after_cancel", mk(16'h4000, 16'd16, 8), -1, 1'b0, 0, 99);
    send("l8_hdr_only", mk(16'h3000, 16'd8, 0), -1, 1'b0, 0, 99);
    send("dup_gaps", mk(16'h3000, 16'd13, 5), -1, 1'b0, 50, 99);
    q = '{8'h01, 8'h02, 8'h03};
    send("trunc1", q, -1, 1'b0, 0, 99);
    q = '{8'h01, 8'h02, 8'h20, 8'h00, 8'h00, 8'h10};
    send("trunc2", q, -1, 1'b0, 0, 99);

    // cancel during the header: silently dropped, not counted
    drive32(1'b1, 1'b0, 32'h0020_3412, 3'd4, 1'b0, 1'b0);
    check_out("hdr_cancel0", 4'd0, 4'd0, 1'b0, 32'd0, 3'd0);
    drive32(1'b1, 1'b1, 32'h0000_1000, 3'd4, 1'b0, 1'b0);
    check_out("hdr_cancel1", 4'd0, 4'd0, 1'b0, 32'd0, 3'd0);
    drive32(1'b1, 1'b0, 32'hAAAA_AAAA, 3'd4, 1'b1, 1'b0);
    check_out("hdr_cancel2", 4'd0, 4'd0, 1'b0, 32'd0, 3'd0);
    chk("hdr_cancel.drop", dc, 16'(drops));
    drive32(1'b0, 1'b0, 32'd0, 3'd4, 1'b0, 1'b0);

    // 64-bit datapath: single-beat header, one short payload beat
    w0 = {8'h00, 8'h00, 8'd11, 8'h00, 8'h00, 8'h30, 8'hCD, 8'hAB};
    w1 = {40'h5A5A5A5A5A, 8'h33, 8'h22, 8'h11};
    drive64(w0, 4'd8, 1'b0);
    chk("w64.hdr_valid", a64_v, 4'd0);
    drive64(w1, 4'd3, 1'b1);
    chk("w64.valid", a64_v, 4'b0100);
    chk("w64.len", a64_l, 4'd3);
    chk("w64.last", a64_last, 1'b1);
    chk("w64.cancel", a64_c, 4'd0);
    chk("w64.data", a64_d, w1);
    drive64(64'h0000_00FF_FFFF_FFFF, 4'd5, 1'b1);
    chk("w64.trunc_drop", a64_dc, 16'd1);
    chk("w64.trunc_valid", a64_v, 4'd0);
    @(negedge clk);
    v64 = 1'b0;

    for (int t = 0; t < 60; t++) begin
      dst = ($urandom_range(0, 3) == 0) ? 16'($urandom) : ports[$urandom_range(0, 3)];
      pb  = $urandom_range(1, 20);
      case ($urandom_range(0, 7))
        0:       ulen = 16'(8 + pb + 1);
        1:       ulen = 16'(8 + pb - 1);
        2:       ulen = 16'($urandom_range(0, 7));
        default: ulen = 16'(8 + pb);
      endcase
      n  = (8 + pb + 3) / 4;
      cb = (n > 2 && $urandom_range(0, 6) == 0) ? $urandom_range(2, n - 1) : -1;
      send("rand", mk(dst, ulen, pb), cb, ($urandom_range(0, 9) == 0), 20, 99);
    end

    // asynchronous reset in the middle of a payload
    send("pre_reset", mk(16'h2000, 16'd20, 12), -1, 1'b0, 0, 3);
    #2;
    nreset = 1'b0;
    valid  = 1'b0;
    drops  = 0;
    #1;
    chk("midrst.valid", av, 4'd0);
    chk("midrst.cancel", ac, 4'd0);
    chk("midrst.last", alast, 1'b0);
    chk("midrst.data", ad, 32'd0);
    chk("midrst.len", al, 3'd0);
    chk("midrst.drop", dc, 16'd0);
    chk("midrst.drop_sat", s_dc, 4'd0);
    @(negedge clk);
    nreset = 1'b1;
    send("post_reset", mk(16'h2000, 16'd20, 12), -1, 1'b0, 0, 99);

    q = '{8'h77};
    for (int i = 0; i < 20; i++) send("sat", q, -1, 1'b0, 0, 99);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
